// File: rtl/spatz_mem_pkg.sv
// Shared types and helpers for the Spatz VLSU memory responder.
package spatz_mem_pkg;

    // Response payload at the default 32-bit bus width; wider instances build the same layout.
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    function automatic int unsigned align_bits(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// Pointer-based FIFO compatible with the common_cells fifo_v3 interface, with optional fall-through.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  dtype                  data_i,
    input  logic                  push_i,
    output dtype                  data_o,
    input  logic                  pop_i
);

    logic [ADDR_DEPTH-1:0] rd_ptr_q, wr_ptr_q;
    logic [ADDR_DEPTH:0]   cnt_q;
    dtype                  mem_q [DEPTH];
    logic                  bypass, do_push, do_pop;
    logic                  unused_testmode;

    function automatic logic [ADDR_DEPTH-1:0] next_ptr(input logic [ADDR_DEPTH-1:0] ptr);
        return (ptr == ADDR_DEPTH'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign unused_testmode = testmode_i;

    // An empty fall-through FIFO hands a same-cycle push straight to the popper without storing it.
    assign bypass  = FALL_THROUGH && (cnt_q == '0) && push_i && pop_i;
    assign do_push = push_i && !full_o && !bypass;
    assign do_pop  = pop_i && !empty_o && !bypass;

    assign full_o  = (cnt_q == (ADDR_DEPTH+1)'(DEPTH));
    assign empty_o = (cnt_q == '0) && !(FALL_THROUGH && push_i);
    assign usage_o = cnt_q[ADDR_DEPTH-1:0];
    assign data_o  = (FALL_THROUGH && (cnt_q == '0)) ? data_i : mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/spatz_mem_delay_line.sv
// Fixed-length register chain carrying a response payload and its valid bit.
module spatz_mem_delay_line
    import spatz_mem_pkg::*;
#(
    parameter int unsigned NumStages = 1,
    parameter type         data_t    = rsp_t
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  vld_i,
    input  data_t rsp_i,
    output logic  vld_o,
    output data_t rsp_o
);

    if (NumStages == 0) begin : gen_bypass
        assign vld_o = vld_i;
        assign rsp_o = rsp_i;
    end else begin : gen_stages
        logic  vld_q [NumStages];
        data_t rsp_q [NumStages];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < NumStages; i++) vld_q[i] <= 1'b0;
            end else begin
                vld_q[0] <= vld_i;
                for (int i = 1; i < NumStages; i++) vld_q[i] <= vld_q[i-1];
            end
        end

        // Payload only matters where the matching valid bit is set, so it is not reset.
        always_ff @(posedge clk_i) begin
            rsp_q[0] <= rsp_i;
            for (int i = 1; i < NumStages; i++) rsp_q[i] <= rsp_q[i-1];
        end

        assign vld_o = vld_q[NumStages-1];
        assign rsp_o = rsp_q[NumStages-1];
    end

endmodule

// File: rtl/spatz_mem_responder.sv
// Responder end of the Spatz VLSU memory interface: word array with byte enables,
// fixed-latency in-order responses and credit-based response back-pressure.
module spatz_mem_responder
    import spatz_mem_pkg::*;
#(
    parameter int unsigned          DataWidth = 32,
    parameter int unsigned          AddrWidth = 32,
    parameter int unsigned          NumWords  = 1024,
    parameter logic [AddrWidth-1:0] BaseAddr  = '0,
    parameter int unsigned          Latency   = 2,
    parameter int unsigned          RspDepth  = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   mem_req_i,
    output logic                   mem_gnt_o,
    input  logic [AddrWidth-1:0]   mem_addr_i,
    input  logic                   mem_we_i,
    input  logic [DataWidth-1:0]   mem_wdata_i,
    input  logic [DataWidth/8-1:0] mem_be_i,
    output logic                   mem_rvalid_o,
    input  logic                   mem_rready_i,
    output logic [DataWidth-1:0]   mem_rdata_o,
    output logic                   mem_err_o
);

    localparam int unsigned          Bytes     = DataWidth / 8;
    localparam int unsigned          AlignW    = align_bits(DataWidth);
    localparam int unsigned          IdxW      = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam int unsigned          CntW      = $clog2(RspDepth + 1);
    localparam int unsigned          FifoW     = (RspDepth > 1) ? $clog2(RspDepth) : 1;
    localparam logic [63:0]          MemBytes  = 64'(NumWords) * 64'(Bytes);
    localparam logic [AddrWidth-1:0] AlignMask = AddrWidth'(Bytes - 1);

    typedef struct packed {
        logic [DataWidth-1:0] rdata;
        logic                 err;
    } rsp_w_t;

    logic [DataWidth-1:0] mem_q [NumWords];
    logic [CntW-1:0]      outstanding_q;
    logic [63:0]          offset;
    logic [IdxW-1:0]      word_idx;
    logic                 addr_err, pop;
    logic                 vld_p0, vld_dl;
    rsp_w_t               rsp_p0, rsp_dl, rsp_head;
    logic                 fifo_full, fifo_empty;
    logic [FifoW-1:0]     fifo_usage;

    assign offset   = 64'(mem_addr_i) - 64'(BaseAddr);
    assign word_idx = IdxW'(offset >> AlignW);
    assign addr_err = (mem_addr_i < BaseAddr) || (offset >= MemBytes)
                   || ((mem_addr_i & AlignMask) != '0);

    // Credits cover everything from grant to pop, so the FIFO always has room for in-flight responses.
    assign mem_gnt_o = rst_ni && mem_req_i && (outstanding_q < CntW'(RspDepth));
    assign pop       = mem_rvalid_o && mem_rready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
        end else begin
            case ({mem_gnt_o, pop})
                2'b10:   outstanding_q <= outstanding_q + 1'b1;
                2'b01:   outstanding_q <= outstanding_q - 1'b1;
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_gnt_o && mem_we_i && !addr_err) begin
            for (int b = 0; b < Bytes; b++) begin
                if (mem_be_i[b]) mem_q[word_idx][b*8 +: 8] <= mem_wdata_i[b*8 +: 8];
            end
        end
    end

    // Stage p0: grant-cycle access result captured at the grant edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) vld_p0 <= 1'b0;
        else         vld_p0 <= mem_gnt_o;
    end

    always_ff @(posedge clk_i) begin
        if (mem_gnt_o) begin
            rsp_p0.err   <= addr_err;
            rsp_p0.rdata <= (!mem_we_i && !addr_err) ? mem_q[word_idx] : '0;
        end
    end

    spatz_mem_delay_line #(
        .NumStages (Latency - 1),
        .data_t    (rsp_w_t)
    ) i_delay_line (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .vld_i  (vld_p0),
        .rsp_i  (rsp_p0),
        .vld_o  (vld_dl),
        .rsp_o  (rsp_dl)
    );

    fifo_v3 #(
        .FALL_THROUGH (1'b1),
        .DEPTH        (RspDepth),
        .dtype        (rsp_w_t)
    ) i_rsp_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (1'b0),
        .testmode_i (1'b0),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .usage_o    (fifo_usage),
        .data_i     (rsp_dl),
        .push_i     (vld_dl),
        .data_o     (rsp_head),
        .pop_i      (pop)
    );

    assign mem_rvalid_o = !fifo_empty;
    assign mem_rdata_o  = mem_rvalid_o ? rsp_head.rdata : '0;
    assign mem_err_o    = mem_rvalid_o ? rsp_head.err : 1'b0;

    assert property (@(posedge clk_i) disable iff (!rst_ni) !(vld_dl && fifo_full && !pop));
    assert property (@(posedge clk_i) disable iff (!rst_ni)
                     fifo_full || (32'(fifo_usage) <= 32'(outstanding_q)));
    assert property (@(posedge clk_i) disable iff (!rst_ni)
                     mem_req_i |-> !$isunknown({mem_addr_i, mem_we_i}));

endmodule

// File: tb/tb_spatz_mem_responder.sv
// Directed bench for spatz_mem_responder at default parameters.
module tb_spatz_mem_responder;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        mem_req_i;
    logic        mem_gnt_o;
    logic [31:0] mem_addr_i;
    logic        mem_we_i;
    logic [31:0] mem_wdata_i;
    logic [3:0]  mem_be_i;
    logic        mem_rvalid_o;
    logic        mem_rready_i;
    logic [31:0] mem_rdata_o;
    logic        mem_err_o;

    int n_checks = 0;
    int n_errors = 0;

    spatz_mem_responder dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .mem_req_i    (mem_req_i),
        .mem_gnt_o    (mem_gnt_o),
        .mem_addr_i   (mem_addr_i),
        .mem_we_i     (mem_we_i),
        .mem_wdata_i  (mem_wdata_i),
        .mem_be_i     (mem_be_i),
        .mem_rvalid_o (mem_rvalid_o),
        .mem_rready_i (mem_rready_i),
        .mem_rdata_o  (mem_rdata_o),
        .mem_err_o    (mem_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One request with rready high; expects its response exactly two cycles after the grant.
    task automatic single(input string tag, input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] b,
                          input logic [31:0] exp_rdata, input logic exp_err);
        int lat;
        mem_req_i = 1'b1; mem_we_i = we; mem_addr_i = a;
        mem_wdata_i = wd; mem_be_i = b; mem_rready_i = 1'b1;
        @(negedge clk_i);
        check({tag, "_gnt"}, 64'(mem_gnt_o), 64'd1);
        @(posedge clk_i); #1;
        mem_req_i = 1'b0; mem_we_i = 1'b0;
        lat = 0;
        do begin
            @(negedge clk_i);
            lat++;
        end while (!mem_rvalid_o && lat < 10);
        check({tag, "_lat"}, 64'(lat), 64'd2);
        check({tag, "_rdata"}, 64'(mem_rdata_o), 64'(exp_rdata));
        check({tag, "_err"}, 64'(mem_err_o), 64'(exp_err));
        @(posedge clk_i); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int   idx, grants, rsp;
        logic g;

        rst_ni = 1'b0; mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = '0;
        mem_wdata_i = '0; mem_be_i = '0; mem_rready_i = 1'b0;
        @(negedge clk_i);
        check("rst_gnt", 64'(mem_gnt_o), 64'd0);
        check("rst_rvalid", 64'(mem_rvalid_o), 64'd0);
        check("rst_rdata", 64'(mem_rdata_o), 64'd0);
        check("rst_err", 64'(mem_err_o), 64'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1; mem_req_i = 1'b0;
        @(posedge clk_i); #1;

        single("t1_wr", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        single("t1_rd", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
        single("t2_wr", 1'b1, 32'h10, 32'h11223344, 4'b0101, 32'h0, 1'b0);
        single("t2_rd", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22BE44, 1'b0);

        for (int i = 0; i < 6; i++)
            single($sformatf("prep%0d", i), 1'b1, 32'(i * 4), 32'hC0DE0000 + 32'(i), 4'hF, 32'h0, 1'b0);

        single("t4_top_wr", 1'b1, 32'hFFC, 32'h5A5A5A5A, 4'hF, 32'h0, 1'b0);
        single("t4_top_rd", 1'b0, 32'hFFC, 32'h0, 4'h0, 32'h5A5A5A5A, 1'b0);
        single("t4_oor_rd", 1'b0, 32'h1000, 32'h0, 4'h0, 32'h0, 1'b1);
        single("t4_misal_rd", 1'b0, 32'h13, 32'h0, 4'h0, 32'h0, 1'b1);
        single("t4_oor_wr", 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
        single("t4_noalias_rd", 1'b0, 32'h0, 32'h0, 4'h0, 32'hC0DE0000, 1'b0);

        // Back-pressure: six reads with rready low, only four credits.
        idx = 0; grants = 0;
        mem_rready_i = 1'b0; mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_i);
            g = mem_gnt_o;
            if (g) grants++;
            @(posedge clk_i); #1;
            if (g) begin idx++; mem_addr_i = 32'(idx * 4); end
        end
        check("t3_grants_stalled", 64'(grants), 64'd4);
        @(negedge clk_i);
        check("t3_gnt_stalled", 64'(mem_gnt_o), 64'd0);
        check("t3_hold_rvalid", 64'(mem_rvalid_o), 64'd1);
        check("t3_hold_rdata", 64'(mem_rdata_o), 64'hC0DE0000);
        @(negedge clk_i);
        check("t3_hold_rdata2", 64'(mem_rdata_o), 64'hC0DE0000);
        check("t3_hold_err", 64'(mem_err_o), 64'd0);
        @(posedge clk_i); #1;
        mem_rready_i = 1'b1;
        rsp = 0;
        for (int c = 0; c < 40 && rsp < 6; c++) begin
            @(negedge clk_i);
            g = mem_gnt_o;
            if (mem_rvalid_o) begin
                check($sformatf("t3_rsp%0d", rsp), 64'(mem_rdata_o), 64'(32'hC0DE0000 + 32'(rsp)));
                rsp++;
            end
            if (g) grants++;
            @(posedge clk_i); #1;
            if (g) begin
                idx++;
                if (idx == 6) mem_req_i = 1'b0;
                else          mem_addr_i = 32'(idx * 4);
            end
        end
        check("t3_nrsp", 64'(rsp), 64'd6);
        check("t3_grants_total", 64'(grants), 64'd6);
        mem_req_i = 1'b0;

        // Reset with three responses outstanding.
        grants = 0;
        mem_rready_i = 1'b0; mem_req_i = 1'b1; mem_addr_i = 32'h8;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            if (mem_gnt_o) grants++;
            @(posedge clk_i); #1;
        end
        mem_req_i = 1'b0;
        check("t5_grants_pre", 64'(grants), 64'd3);
        @(negedge clk_i);
        check("t5_rvalid_pre", 64'(mem_rvalid_o), 64'd1);
        @(posedge clk_i); #1;
        rst_ni = 1'b0; mem_req_i = 1'b1;
        #1;
        check("t5_rvalid_in_rst", 64'(mem_rvalid_o), 64'd0);
        check("t5_rdata_in_rst", 64'(mem_rdata_o), 64'd0);
        check("t5_gnt_in_rst", 64'(mem_gnt_o), 64'd0);
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_ni = 1'b1; mem_addr_i = 32'h4;
        grants = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            if (c == 0) begin
                check("t5_rvalid_post", 64'(mem_rvalid_o), 64'd0);
                check("t5_rdata_post", 64'(mem_rdata_o), 64'd0);
            end
            if (mem_rvalid_o) check($sformatf("t5_head%0d", c), 64'(mem_rdata_o), 64'hC0DE0001);
            if (mem_gnt_o) grants++;
            @(posedge clk_i); #1;
        end
        check("t5_grants_post", 64'(grants), 64'd4);
        mem_req_i = 1'b0; mem_rready_i = 1'b1;
        rsp = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            if (mem_rvalid_o) rsp++;
            @(posedge clk_i); #1;
        end
        check("t5_drain", 64'(rsp), 64'd4);

        // Credit return timing and sustained throughput.
        grants = 0;
        mem_rready_i = 1'b0; mem_req_i = 1'b1; mem_addr_i = 32'h4;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            if (mem_gnt_o) grants++;
            @(posedge clk_i); #1;
        end
        check("t6_fill", 64'(grants), 64'd4);
        mem_rready_i = 1'b1;
        @(negedge clk_i);
        check("t6_pop_gnt", 64'(mem_gnt_o), 64'd0);
        check("t6_pop_rvalid", 64'(mem_rvalid_o), 64'd1);
        @(posedge clk_i); #1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_i);
            check($sformatf("t6_gnt%0d", c), 64'(mem_gnt_o), 64'd1);
            check($sformatf("t6_rvalid%0d", c), 64'(mem_rvalid_o), 64'd1);
            check($sformatf("t6_rdata%0d", c), 64'(mem_rdata_o), 64'hC0DE0001);
            @(posedge clk_i); #1;
        end
        mem_req_i = 1'b0;
        rsp = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            if (mem_rvalid_o) rsp++;
            @(posedge clk_i); #1;
        end
        check("t6_drain", 64'(rsp), 64'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
